// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the MEM-stage data-memory access controller:
//   - FSM state encoding
//   - fun3 access width/sign codes
//   - default bus timeout
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Request/grant/response data-memory bus.
//   mem_req    : request (master -> slave)
//   mem_we     : 1 = write
//   mem_addr   : word-aligned byte address
//   mem_wdata  : replicated store data
//   mem_be     : byte enables
//   mem_gnt    : request accepted (slave -> master)
//   mem_rvalid : read data valid
//   mem_rdata  : read data
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational load/store alignment helper.
//   load_i/store_i/fun3_i/addr_lo_i : request decode (IDLE-cycle inputs)
//   wdata_i                         : raw rs2 store data
//   be_o, wdata_o                   : byte enables and replicated store data
//   fault_o                         : illegal width, misalignment or load+store
//   ld_fun3_i, ld_off_i, rdata_i    : registered load width/offset + bus data
//   ld_data_o                       : extracted and extended load result
// ---------------------------------------------------------------------------
module lsu_align
  import mem_ctrl_pkg::*;
(
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  fun3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        fault_o,
  input  logic [2:0]  ld_fun3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic        misaligned;
  logic        ill_width;
  logic [31:0] rshift;

  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    misaligned = 1'b0;
    // fun3[1:0] carries the width; fun3[2] only selects zero-extension.
    case (fun3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        misaligned = addr_lo_i[0];
      end
      default: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misaligned = (addr_lo_i != 2'b00);
      end
    endcase

    ill_width = 1'b0;
    if (load_i)
      ill_width = (fun3_i == 3'b011) || (fun3_i == 3'b111);
    else if (store_i)
      ill_width = fun3_i[2] || (fun3_i[1:0] == 2'b11);

    fault_o = (load_i && store_i) || ill_width || misaligned;
  end

  // Halfword offsets are always 0 or 2, so one byte-granular shift serves both widths.
  assign rshift = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    case (ld_fun3_i)
      F3_B:    ld_data_o = {{24{rshift[7]}}, rshift[7:0]};
      F3_BU:   ld_data_o = {24'h0, rshift[7:0]};
      F3_H:    ld_data_o = {{16{rshift[15]}}, rshift[15:0]};
      F3_HU:   ld_data_o = {16'h0, rshift[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage data-memory access sequencer for an RV32I pipeline.
//   clk, rst_n          : clock, synchronous active-low reset
//   load_i, store_i     : access type from decode
//   fun3_i, addr_i      : access width/sign and byte address
//   wdata_i, rd_i       : store data and load destination
//   flush_i             : kill the MEM-stage access
//   stall_o             : hold the pipeline while an access is in flight
//   mem                 : request/grant/response bus (master side)
//   wb_valid_o/rd/data  : one-cycle load writeback
//   fault_o, timeout_o  : misaligned/illegal-width pulse, bus timeout pulse
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                store_i,
  input  logic [2:0]          fun3_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wdata_i,
  input  logic [4:0]          rd_i,
  input  logic                flush_i,
  output logic                stall_o,
  mem_access_ctrl_if.master   mem,
  output logic                wb_valid_o,
  output logic [4:0]          wb_rd_o,
  output logic [31:0]         wb_data_o,
  output logic                fault_o,
  output logic                timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               kill_q, kill_d;
  logic               to_q, to_d;
  logic               fault_q, fault_d;
  logic [29:0]        addr_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic               we_q;
  logic [2:0]         fun3_q;
  logic [4:0]         rd_q;
  logic [1:0]         off_q;
  logic [31:0]        data_q;

  logic               access, bad, latch, capture;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c, ld_data_c;

  lsu_align u_align (
    .load_i    (load_i),
    .store_i   (store_i),
    .fun3_i    (fun3_i),
    .addr_lo_i (addr_i[1:0]),
    .wdata_i   (wdata_i),
    .be_o      (be_c),
    .wdata_o   (wdata_c),
    .fault_o   (bad),
    .ld_fun3_i (fun3_q),
    .ld_off_i  (off_q),
    .rdata_i   (mem.mem_rdata),
    .ld_data_o (ld_data_c)
  );

  assign access = (load_i || store_i) && !flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    to_d    = to_q;
    fault_d = 1'b0;
    latch   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (bad) begin
            fault_d = 1'b1;
          end else begin
            latch   = 1'b1;
            state_d = ST_REQ;
            cnt_d   = '0;
            kill_d  = 1'b0;
            to_d    = 1'b0;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (flush_i && !mem.mem_gnt) begin
          state_d = ST_IDLE;
        end else if (mem.mem_gnt) begin
          // Once granted the bus transaction is committed; a flush only hides the result.
          if (flush_i) kill_d = 1'b1;
          if (we_q) begin
            state_d = ST_DONE;
          end else if (mem.mem_rvalid) begin
            capture = 1'b1;
            state_d = ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            to_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (mem.mem_rvalid) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      to_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      to_q    <= to_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fun3_q  <= '0;
      rd_q    <= '0;
      off_q   <= '0;
      data_q  <= '0;
    end else begin
      if (latch) begin
        addr_q  <= addr_i[31:2];
        be_q    <= be_c;
        wdata_q <= wdata_c;
        we_q    <= store_i;
        fun3_q  <= fun3_i;
        rd_q    <= rd_i;
        off_q   <= addr_i[1:0];
      end
      if (capture) data_q <= ld_data_c;
    end
  end

  assign stall_o       = ((state_q == ST_IDLE) && access && !bad) ||
                         (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign mem.mem_req   = (state_q == ST_REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q, 2'b00};
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

  assign wb_valid_o = (state_q == ST_DONE) && !we_q && !kill_q && !to_q;
  assign wb_rd_o    = rd_q;
  assign wb_data_o  = data_q;
  assign fault_o    = fault_q;
  assign timeout_o  = (state_q == ST_DONE) && to_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_i, store_i, flush_i;
  logic [2:0]  fun3_i;
  logic [31:0] addr_i, wdata_i;
  logic [4:0]  rd_i;
  logic        stall_o, wb_valid_o, fault_o, timeout_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_i),
    .store_i    (store_i),
    .fun3_i     (fun3_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rd_i       (rd_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .mem        (bus.master),
    .wb_valid_o (wb_valid_o),
    .wb_rd_o    (wb_rd_o),
    .wb_data_o  (wb_data_o),
    .fault_o    (fault_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gnt_wait;
    int          rv_dly;
    int          e_req;
    int          e_stall;
    int          e_wb;
    int          e_fault;
    int          e_to;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_wbd;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE; runs 12 cycles with a simple bus responder.
  task automatic run_vec(input string tag, input vec_t v);
    int reqn, stalln, wbn, fltn, ton, gcyc;
    logic drop, stable, we_s;
    logic [3:0]  be_s;
    logic [31:0] a_s, wd_s, wbd_s;
    logic [4:0]  rd_s;
    reqn = 0; stalln = 0; wbn = 0; fltn = 0; ton = 0; gcyc = -1;
    drop = 1'b0; stable = 1'b1; we_s = 1'b0;
    be_s = '0; a_s = '0; wd_s = '0; wbd_s = '0; rd_s = '0;
    load_i = v.ld; store_i = v.st; fun3_i = v.f3; addr_i = v.addr;
    wdata_i = v.wd; rd_i = v.rd; bus.mem_rdata = v.rdata;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (stall_o) stalln++;
      if (bus.mem_req) begin
        if (reqn == 0) begin
          be_s = bus.mem_be; a_s = bus.mem_addr; wd_s = bus.mem_wdata; we_s = bus.mem_we;
        end else if (bus.mem_be !== be_s || bus.mem_addr !== a_s || bus.mem_wdata !== wd_s) begin
          stable = 1'b0;
        end
        if (reqn == v.gnt_wait) begin
          bus.mem_gnt = 1'b1;
          gcyc = cyc;
          if (v.ld && !v.st && v.rv_dly == 0) bus.mem_rvalid = 1'b1;
        end
        reqn++;
      end
      if (gcyc >= 0 && v.rv_dly > 0 && cyc == gcyc + v.rv_dly) bus.mem_rvalid = 1'b1;
      if (wb_valid_o) begin wbn++; wbd_s = wb_data_o; rd_s = wb_rd_o; end
      if (fault_o) fltn++;
      if (timeout_o) ton++;
      if (!stall_o) drop = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (drop) begin load_i = 1'b0; store_i = 1'b0; end
    end
    chk({tag, " req_cycles"}, reqn, v.e_req);
    chk({tag, " stall_cycles"}, stalln, v.e_stall);
    chk({tag, " wb_pulses"}, wbn, v.e_wb);
    chk({tag, " fault_pulses"}, fltn, v.e_fault);
    chk({tag, " timeout_pulses"}, ton, v.e_to);
    if (v.e_req > 0) begin
      chk({tag, " be"}, be_s, v.e_be);
      chk({tag, " addr"}, a_s, {v.addr[31:2], 2'b00});
      chk({tag, " we"}, we_s, v.st);
      if (v.st) chk({tag, " wdata"}, wd_s, v.e_wd);
      if (v.e_req > 1) chk({tag, " bus_stable"}, stable, 1'b1);
    end
    if (v.e_wb > 0) begin
      chk({tag, " wb_data"}, wbd_s, v.e_wbd);
      chk({tag, " wb_rd"}, rd_s, v.rd);
    end
  endtask

  initial begin
    int wbn;
    vec_t v;
    //          ld st f3      addr          wd            rd     rdata         gw  rv req stl wb f  to be       wd            wbd
    vecs[0]  = '{0, 1, F3_W,  32'h100,  32'hDEADBEEF, 5'd0,  32'h0,        0,  0, 1, 2, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1, 0, F3_B,  32'h203,  32'h0,        5'd5,  32'h80FFFF7F, 0,  1, 1, 3, 1, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1, 0, F3_BU, 32'h203,  32'h0,        5'd6,  32'h80FFFF7F, 0,  1, 1, 3, 1, 0, 0, 4'b1000, 32'h0,        32'h00000080};
    vecs[3]  = '{0, 1, F3_H,  32'h2,    32'h1234ABCD, 5'd0,  32'h0,        0,  0, 1, 2, 0, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[4]  = '{1, 0, F3_H,  32'h1,    32'h0,        5'd1,  32'h0,        0,  0, 0, 0, 0, 1, 0, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{0, 1, F3_B,  32'h1,    32'h000000A5, 5'd0,  32'h0,        0,  0, 1, 2, 0, 0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[6]  = '{1, 0, F3_H,  32'h2,    32'h0,        5'd7,  32'h80011234, 0,  0, 1, 2, 1, 0, 0, 4'b1100, 32'h0,        32'hFFFF8001};
    vecs[7]  = '{1, 0, F3_HU, 32'h0,    32'h0,        5'd8,  32'h1234F00D, 0,  1, 1, 3, 1, 0, 0, 4'b0011, 32'h0,        32'h0000F00D};
    vecs[8]  = '{1, 0, F3_W,  32'h10,   32'h0,        5'd9,  32'hCAFEBABE, 2,  1, 3, 5, 1, 0, 0, 4'b1111, 32'h0,        32'hCAFEBABE};
    vecs[9]  = '{0, 1, F3_W,  32'h102,  32'h11111111, 5'd0,  32'h0,        0,  0, 0, 0, 0, 1, 0, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1, 0, 3'b011,32'h0,    32'h0,        5'd2,  32'h0,        0,  0, 0, 0, 0, 1, 0, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{0, 1, 3'b100,32'h0,    32'h0,        5'd0,  32'h0,        0,  0, 0, 0, 0, 1, 0, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1, 1, F3_W,  32'h0,    32'h0,        5'd3,  32'h0,        0,  0, 0, 0, 0, 1, 0, 4'b0000, 32'h0,        32'h0};
    vecs[13] = '{1, 0, F3_WU, 32'h8,    32'h0,        5'd10, 32'h87654321, 0,  1, 1, 3, 1, 0, 0, 4'b1111, 32'h0,        32'h87654321};
    vecs[14] = '{1, 0, F3_B,  32'h1,    32'h0,        5'd11, 32'h00007F00, 0,  1, 1, 3, 1, 0, 0, 4'b0010, 32'h0,        32'h0000007F};
    vecs[15] = '{1, 0, F3_W,  32'h40,   32'h0,        5'd12, 32'h0,        99, 0, 4, 5, 0, 0, 1, 4'b1111, 32'h0,        32'h0};

    rst_n = 1'b0; load_i = 0; store_i = 0; flush_i = 0; fun3_i = 0;
    addr_i = 0; wdata_i = 0; rd_i = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst stall", stall_o, 1'b0);
    chk("rst req", bus.mem_req, 1'b0);
    chk("rst wb_valid", wb_valid_o, 1'b0);
    chk("rst fault", fault_o, 1'b0);
    chk("rst timeout", timeout_o, 1'b0);
    chk("rst addr", bus.mem_addr, 32'h0);
    chk("rst wb_data", wb_data_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Late rvalid after the timeout must be ignored.
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    #1;
    chk("late_rv wb_valid", wb_valid_o, 1'b0);
    chk("late_rv stall", stall_o, 1'b0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    #1;
    chk("late_rv wb_valid next", wb_valid_o, 1'b0);
    @(negedge clk);

    // Flush while REQ is waiting for grant.
    load_i = 1; fun3_i = F3_W; addr_i = 32'h20; rd_i = 5'd3;
    #1; chk("flreq stall idle", stall_o, 1'b1);
    @(negedge clk); #1;
    chk("flreq req", bus.mem_req, 1'b1);
    flush_i = 1; load_i = 0;
    @(negedge clk);
    flush_i = 0;
    #1;
    chk("flreq req dropped", bus.mem_req, 1'b0);
    chk("flreq stall", stall_o, 1'b0);
    wbn = 0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); #1; if (wb_valid_o) wbn++; end
    chk("flreq wb_pulses", wbn, 0);
    @(negedge clk);

    // Flush while WAIT: access completes, writeback suppressed.
    load_i = 1; fun3_i = F3_W; addr_i = 32'h24; rd_i = 5'd4; bus.mem_rdata = 32'h11111111;
    @(negedge clk); #1;
    chk("flwait req", bus.mem_req, 1'b1);
    bus.mem_gnt = 1;
    @(negedge clk);
    bus.mem_gnt = 0;
    #1; chk("flwait stall wait", stall_o, 1'b1);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0; bus.mem_rvalid = 1;
    #1; chk("flwait stall held", stall_o, 1'b1);
    @(negedge clk);
    bus.mem_rvalid = 0;
    #1;
    chk("flwait wb_valid", wb_valid_o, 1'b0);
    chk("flwait stall done", stall_o, 1'b0);
    load_i = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset during WAIT, then a normal load afterwards.
    load_i = 1; fun3_i = F3_W; addr_i = 32'h30; rd_i = 5'd13;
    @(negedge clk); #1;
    bus.mem_gnt = 1;
    @(negedge clk);
    bus.mem_gnt = 0; rst_n = 0; load_i = 0;
    @(negedge clk); #1;
    chk("rstw stall", stall_o, 1'b0);
    chk("rstw req", bus.mem_req, 1'b0);
    chk("rstw we", bus.mem_we, 1'b0);
    chk("rstw addr", bus.mem_addr, 32'h0);
    chk("rstw be", bus.mem_be, 4'h0);
    chk("rstw wdata", bus.mem_wdata, 32'h0);
    chk("rstw wb_valid", wb_valid_o, 1'b0);
    chk("rstw wb_rd", wb_rd_o, 5'd0);
    chk("rstw timeout", timeout_o, 1'b0);
    chk("rstw fault", fault_o, 1'b0);
    rst_n = 1;
    @(negedge clk);
    v = '{1, 0, F3_W, 32'h30, 32'h0, 5'd13, 32'h0BADF00D, 0, 1, 1, 3, 1, 0, 0, 4'b1111, 32'h0, 32'h0BADF00D};
    run_vec("post_rst", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the RV32I pipeline's MEM stage.
- Takes the decoded Load/Store/fun3 controls plus the ALU address and store data.
- Drives a request/grant/response data bus, generates byte enables and store-data replication, and sign- or zero-extends load data.
- Stalls the pipeline until each access completes, and flags misaligned or illegal-width accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed in REQ+WAIT before the access is abandoned (1..255).
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- load_i  in  1  MEM-stage instruction is a load
- store_i  in  1  MEM-stage instruction is a store
- fun3_i  in  3  access width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu, 110 treated as w
- addr_i  in  32  byte address from the ALU
- wdata_i  in  32  rs2 store data
- rd_i  in  5  load destination register
- flush_i  in  1  kill the MEM-stage access
- stall_o  out  1  hold the pipeline
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata_o  out  32  replicated store data
- mem_be_o  out  4  byte enables
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data
- wb_valid_o  out  1  load result valid (1-cycle pulse)
- wb_rd_o  out  5  load destination
- wb_data_o  out  32  extended load data
- fault_o  out  1  misaligned/illegal-width pulse
- timeout_o  out  1  bus timeout pulse

Behaviour:
- Reset: rst_n low at a clk edge gives state IDLE and clears the counter. All registered outputs go to 0. The reset aborts any in-flight access; no wb_valid_o is produced for it.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, access = (load_i|store_i) & !flush_i:
  - Width illegal (load fun3 011/111, store fun3 ≥011) or misaligned (h with addr[0]=1, w with addr[1:0]≠0): fault_o=1 on the next cycle. No bus activity, no stall, stay in IDLE.
  - Otherwise: register addr, be, wdata, we, fun3, rd and offset. Go to REQ. stall_o=1 combinationally in this cycle.
- REQ: mem_req_o=1, with all bus outputs stable until grant.
  - gnt with a store: go to DONE.
  - gnt with a load and rvalid in the same cycle: capture data, go to DONE.
  - gnt with a load and no rvalid: go to WAIT.
  - flush_i before gnt: drop the request, go to IDLE, no writeback.
- WAIT: mem_req_o=0. On rvalid, capture and extend data, then go to DONE. flush_i here sets a kill flag: the access completes, but wb_valid_o is suppressed.
- DONE: stall_o=0. wb_valid_o=1 only for unkilled loads, with wb_rd_o/wb_data_o valid. Next state is IDLE.
- stall_o = (IDLE & legal access) | REQ | WAIT. The pipeline therefore advances exactly once, at the end of DONE.
- Latency: a store with immediate grant is 3 cycles (IDLE→REQ→DONE). A load with 1-cycle response is 4 cycles.
- Timeout:
  - The counter clears on entering REQ and increments in REQ and WAIT.
  - When the count reaches TIMEOUT_CYCLES: mem_req_o is dropped, timeout_o pulses in DONE, and wb_valid_o=0.
  - A late rvalid is ignored.
- Byte enables: sb gives 0001<<addr[1:0]. sh gives 0011<<{addr[1],1'b0}. sw gives 1111.
- Store data: sb is {4{wdata[7:0]}}, sh is {2{wdata[15:0]}}, sw is wdata.
- Load extension: select the byte/half from rdata at the offset. lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- load_i and store_i both high: treated as a fault.
- mem_gnt_i/mem_rvalid_i are ignored in IDLE and DONE.

Decomposition:
- Package mem_ctrl_pkg holds:
  - the state encoding (IDLE=2'b00, REQ=01, WAIT=10, DONE=11)
  - fun3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU, F3_WU)
  - TIMEOUT default
- One combinational sub-module, lsu_align, does byte-enable generation, store replication, load extraction/extension and the fault check.
- The FSM, counter and registers stay in mem_access_ctrl.

Test Plan:
- sw addr 0x100, data 0xDEADBEEF, gnt on first REQ cycle → mem_be_o=1111 and mem_wdata_o=0xDEADBEEF. stall_o is high for 2 cycles, then low in DONE, and wb_valid_o stays 0.
- lb addr 0x203, rdata 0x80FF_FF7F with rvalid 1 cycle after gnt → mem_be_o=1000. wb_data_o=0xFFFFFF80 and wb_valid_o pulses 1 cycle with wb_rd_o=rd_i. Repeating with lbu gives 0x00000080.
- sh addr 0x0002, data 0x1234ABCD → mem_be_o=1100 and mem_wdata_o=0xABCDABCD. lh at addr 0x0001 → fault_o=1 the next cycle, with no mem_req_o and no stall.
- Load with gnt withheld for TIMEOUT_CYCLES (set to 4) → mem_req_o drops after 4 REQ cycles. timeout_o pulses, wb_valid_o=0, and a later rvalid is ignored.
- flush_i asserted in REQ before gnt → mem_req_o drops the next cycle, back to IDLE, no wb_valid_o. flush_i in WAIT → access completes, wb_valid_o=0.
- rst_n low during WAIT → next cycle all outputs are 0 and the state is IDLE. A new lw accepted after reset completes normally.
